// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with snapshot debounce and movement decode
module keypad_scan #(
    parameter int         SCAN_DIV       = 50000,
    parameter int         DEBOUNCE_SCANS = 4,
    parameter logic [3:0] KEY_UP         = 4'd1,
    parameter logic [3:0] KEY_DOWN       = 4'd9,
    parameter logic [3:0] KEY_LEFT       = 4'd4,
    parameter logic [3:0] KEY_RIGHT      = 4'd6
) (
    input  logic       sys_clk,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] mov,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [1:0]    col;
    logic [DW-1:0] dwell;
    logic [15:0]   snap;
    logic [15:0]   prev;
    logic [15:0]   deb;
    logic [15:0]   deb_q;
    logic [SW-1:0] stable;

    logic          capture;
    logic [15:0]   snap_full;
    logic [3:0]    code_next;

    // Capture strobe and the snapshot as it will look once the driven column's rows are merged in
    always_comb begin
        capture   = (dwell == DWELL_LAST);
        snap_full = snap;
        for (int r = 0; r < 4; r++) begin
            snap_full[r*4 + int'(col)] = ~row_in[r];
        end
    end

    // One-cold column drive derived from the column index
    always_comb begin
        col_out = ~(4'b0001 << col);
    end

    // Lowest-index debounced key, zero when nothing is held
    always_comb begin
        code_next = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (deb[i]) begin
                code_next = 4'(i);
            end
        end
    end

    // Column sequencer: dwell on each column, advance after the capture cycle
    always_ff @(posedge sys_clk) begin
        if (RST) begin
            col   <= 2'd0;
            dwell <= '0;
        end else if (capture) begin
            dwell <= '0;
            col   <= col + 2'd1;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Snapshot assembly and whole-map debounce, evaluated when column 3 completes a scan
    always_ff @(posedge sys_clk) begin
        if (RST) begin
            snap   <= '0;
            prev   <= '0;
            deb    <= '0;
            stable <= '0;
        end else if (capture) begin
            snap <= snap_full;
            if (col == 2'd3) begin
                if (snap_full != prev) begin
                    prev   <= snap_full;
                    stable <= '0;
                end else if (stable != STABLE_MAX) begin
                    stable <= stable + SW'(1);
                    if (stable == STABLE_MAX - SW'(1)) begin
                        deb <= snap_full;
                    end
                end
            end
        end
    end

    // Registered outputs follow the debounced map one cycle later; press pulses on newly held keys
    always_ff @(posedge sys_clk) begin
        if (RST) begin
            deb_q     <= '0;
            mov       <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_press <= 1'b0;
        end else begin
            deb_q     <= deb;
            mov       <= {deb[KEY_UP], deb[KEY_DOWN], deb[KEY_LEFT], deb[KEY_RIGHT]};
            key_code  <= code_next;
            key_valid <= |deb;
            key_press <= |(deb & ~deb_q);
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan with a behavioural keypad and reference model
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DS = 2;
    localparam int KU = 1;
    localparam int KD = 9;
    localparam int KL = 4;
    localparam int KR = 6;

    logic        sys_clk = 1'b0;
    logic        RST;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  mov;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_press;

    logic [15:0] keys;
    int          tests = 0;
    int          fails = 0;

    keypad_scan #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DS),
        .KEY_UP(4'd1),
        .KEY_DOWN(4'd9),
        .KEY_LEFT(4'd4),
        .KEY_RIGHT(4'd6)
    ) dut (
        .sys_clk(sys_clk),
        .RST(RST),
        .row_in(row_in),
        .col_out(col_out),
        .mov(mov),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_press(key_press)
    );

    always #5 sys_clk = ~sys_clk;

    // Physical keypad: a held key pulls its row low while its column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col_out[c] == 1'b0 && keys[r*4 + c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Reference model: cycle count since reset gives column and capture points; debounce is
    // "commit once the same full snapshot has been seen DS+1 times in a row" (reset map counts once)
    int          n;
    int          m_run;
    logic [15:0] m_snap, m_last, m_deb, m_deb_d;
    logic [3:0]  e_mov, e_code;
    logic        e_valid, e_press;
    logic        m_live = 1'b0;

    always @(posedge sys_clk) begin
        if (RST) begin
            n = 0; m_run = 1;
            m_snap = '0; m_last = '0; m_deb = '0; m_deb_d = '0;
            e_mov = '0; e_code = '0; e_valid = 1'b0; e_press = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            e_mov   = {m_deb[KU], m_deb[KD], m_deb[KL], m_deb[KR]};
            e_valid = |m_deb;
            e_code  = lowest(m_deb);
            e_press = |(m_deb & ~m_deb_d);
            m_deb_d = m_deb;
            if (n % SD == SD - 1) begin
                int c;
                c = (n / SD) % 4;
                for (int r = 0; r < 4; r++) m_snap[r*4 + c] = keys[r*4 + c];
                if (c == 3) begin
                    if (m_snap == m_last) m_run++;
                    else begin
                        m_last = m_snap;
                        m_run = 1;
                    end
                    if (m_run == DS + 1) m_deb = m_snap;
                end
            end
            n++;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge
    always @(negedge sys_clk) begin
        if (m_live) begin
            logic [3:0] e_col;
            e_col = ~(4'b0001 << ((n / SD) % 4));
            chk("cyc_col_out", 16'(col_out), 16'(e_col));
            chk("cyc_mov", 16'(mov), 16'(e_mov));
            chk("cyc_key_code", 16'(key_code), 16'(e_code));
            chk("cyc_key_valid", 16'(key_valid), 16'(e_valid));
            chk("cyc_key_press", 16'(key_press), 16'(e_press));
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge sys_clk);
    endtask

    // Wait (bounded) for {mov,key_code,key_valid} to reach target, then count presses over a short tail
    task automatic wait_for(input logic [8:0] target, input int limit, input string name,
                            output int took, output int presses);
        bit hit;
        hit = 1'b0;
        presses = 0;
        took = 0;
        for (int t = 1; t <= limit && !hit; t++) begin
            @(negedge sys_clk);
            if (key_press) presses++;
            if ({mov, key_code, key_valid} === target) begin
                hit = 1'b1;
                took = t;
            end
        end
        if (!hit) begin
            chk({name, "_timeout"}, 16'({mov, key_code, key_valid}), 16'(target));
            took = limit + 1;
        end
        for (int t = 0; t < 8; t++) begin
            @(negedge sys_clk);
            if (key_press) presses++;
        end
    endtask

    initial begin
        int took, pr, bad;
        logic [3:0] seq [4];
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;

        // Reset state and column walk
        RST = 1'b1; keys = '0;
        cycles(3);
        chk("reset_col_out", 16'(col_out), 16'hE);
        chk("reset_mov", 16'(mov), 16'h0);
        chk("reset_key_valid", 16'(key_valid), 16'h0);
        RST = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            cycles(4);
            chk("col_step", 16'(col_out), 16'(seq[s % 4]));
        end

        // Right key held from reset release
        RST = 1'b1; keys = 16'h0040;
        cycles(2);
        RST = 1'b0;
        wait_for({4'b0001, 4'd6, 1'b1}, 66, "right_press", took, pr);
        chk("right_press_latency", 16'(took), 16'd49);
        chk("right_press_pulses", 16'(pr), 16'd1);
        keys = '0;
        wait_for({4'b0000, 4'd0, 1'b0}, 66, "right_release", took, pr);
        chk("right_release_in_bound", 16'(took <= 66), 16'd1);
        chk("right_release_pulses", 16'(pr), 16'd0);

        // Bounce: key 1 toggles every scan, never committed
        bad = 0;
        for (int s = 0; s < 5; s++) begin
            keys = (s % 2 == 0) ? 16'h0002 : 16'h0000;
            for (int t = 0; t < 16; t++) begin
                @(negedge sys_clk);
                if (mov != 0 || key_valid || key_press) bad++;
            end
        end
        keys = '0;
        for (int t = 0; t < 66; t++) begin
            @(negedge sys_clk);
            if (mov != 0 || key_valid || key_press) bad++;
        end
        chk("bounce_no_assert", 16'(bad), 16'd0);

        // Multi-key: up+down, then add left
        keys = 16'h0202;
        wait_for({4'b1100, 4'd1, 1'b1}, 66, "multi_ud", took, pr);
        chk("multi_ud_pulses", 16'(pr), 16'd1);
        keys = 16'h0212;
        wait_for({4'b1110, 4'd1, 1'b1}, 66, "multi_udl", took, pr);
        chk("multi_udl_pulses", 16'(pr), 16'd1);
        keys = '0;
        wait_for({4'b0000, 4'd0, 1'b0}, 66, "multi_release", took, pr);

        // Non-mapped key 15
        keys = 16'h8000;
        wait_for({4'b0000, 4'd15, 1'b1}, 66, "key15", took, pr);
        chk("key15_pulses", 16'(pr), 16'd1);
        keys = '0;
        wait_for({4'b0000, 4'd0, 1'b0}, 66, "key15_release", took, pr);

        // Reset in the middle of a scan while a key is debounced
        keys = 16'h0040;
        wait_for({4'b0001, 4'd6, 1'b1}, 66, "mid_pre", took, pr);
        took = 0;
        while (col_out !== 4'b1011 && took < 20) begin
            @(negedge sys_clk);
            took++;
        end
        chk("mid_reach_col2", 16'(col_out), 16'hB);
        RST = 1'b1;
        cycles(1);
        chk("mid_reset_mov", 16'(mov), 16'h0);
        chk("mid_reset_col_out", 16'(col_out), 16'hE);
        RST = 1'b0;
        wait_for({4'b0001, 4'd6, 1'b1}, 66, "mid_recover", took, pr);
        chk("mid_recover_latency", 16'(took), 16'd49);

        // Randomized key patterns, bounce and occasional resets; checked every cycle by the model
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      keys = '0;
            else if (r < 6) keys = 16'(1) << $urandom_range(0, 15);
            else if (r < 8) keys = 16'($urandom) & 16'h0252;
            else            keys = 16'($urandom);
            if ($urandom_range(0, 14) == 0) begin
                RST = 1'b1;
                cycles(1);
                RST = 1'b0;
            end
            cycles($urandom_range(3, 90));
        end
        keys = '0;
        cycles(80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
